reaction_timer: RTL

Game-control stage directly upstream of the high-score updater. Runs the round state machine (idle → random wait → react → done), measures the player's reaction time in milliseconds, and drives the 2-bit `state` and 14-bit `current_score` buses that the high-score stage consumes. A false start or timeout produces the worst score, `SCORE_MAX`, so it can never become a high score.

---
 rtl/game_pkg.sv | 19 +
 rtl/ms_tick_gen.sv | 16 +
 rtl/reaction_timer.sv | 94 +++++++++
 3 files changed

// File: rtl/game_pkg.sv
// game_pkg: round-state encodings, score format and LFSR step shared by the game stages
package game_pkg;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_REACT = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;
  localparam int SCORE_W = 14;
  localparam int SCORE_MAX = 9999;
  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_WAIT = ST_WAIT,
    S_REACT = ST_REACT,
    S_DONE = ST_DONE
  } state_t;
  // Fibonacci LFSR, taps 16,14,13,11
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction
endpackage

// File: rtl/ms_tick_gen.sv
// ms_tick_gen: one-cycle tick every TICK_DIV clocks, restartable by clr
module ms_tick_gen #(
  parameter int TICK_DIV = 50000
) (
  input  logic iCLK,
  input  logic iRST,
  input  logic clr,
  output logic tick
);
  localparam int W = $clog2(TICK_DIV + 1);
  logic [W-1:0] r_cnt;
  assign tick = r_cnt == W'(TICK_DIV - 1);
  always_ff @(posedge iCLK) begin
    r_cnt <= (iRST || clr || tick) ? '0 : r_cnt + 1'b1;
  end
endmodule

// File: rtl/reaction_timer.sv
// reaction_timer: round FSM (idle, random wait, react, done) measuring reaction time in ms
module reaction_timer #(
  parameter int TICK_DIV = 50000,
  parameter int MIN_DELAY_MS = 1000,
  parameter int SCORE_MAX = game_pkg::SCORE_MAX,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                          iCLK,
  input  logic                          iRST,
  input  logic                          start_btn,
  input  logic                          react_btn,
  output logic [1:0]                    state,
  output logic [game_pkg::SCORE_W-1:0]  current_score,
  output logic                          led_go,
  output logic                          false_start
);
  import game_pkg::*;
  state_t r_state, w_state_n;
  logic [11:0] r_delay, w_delay_n;
  logic [SCORE_W-1:0] r_score, w_score_n, w_score_inc;
  logic r_fs, w_fs_n;
  logic [15:0] r_lfsr;
  logic r_start_q, r_react_q, r_start_e, r_react_e;
  logic w_tick;

  ms_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .iCLK(iCLK),
    .iRST(iRST),
    .clr (w_state_n != r_state),
    .tick(w_tick)
  );

  assign w_score_inc = r_score + 1'b1;

  // react_edge is checked before tick so a press on a tick cycle never adds a ms
  always_comb begin
    w_state_n = r_state;
    w_delay_n = r_delay;
    w_score_n = r_score;
    w_fs_n = r_fs;
    case (r_state)
      S_IDLE: if (r_start_e) begin
        w_state_n = S_WAIT;
        w_delay_n = 12'(MIN_DELAY_MS) + 12'(r_lfsr[10:0]);
        w_score_n = '0;
        w_fs_n = 1'b0;
      end
      S_WAIT: if (r_react_e) begin
        w_state_n = S_DONE;
        w_score_n = SCORE_W'(SCORE_MAX);
        w_fs_n = 1'b1;
      end else if (w_tick) begin
        w_delay_n = r_delay - 1'b1;
        w_state_n = r_delay == 12'd1 ? S_REACT : S_WAIT;
      end
      S_REACT: if (r_react_e) begin
        w_state_n = S_DONE;
      end else if (w_tick) begin
        w_score_n = w_score_inc;
        w_state_n = w_score_inc == SCORE_W'(SCORE_MAX) ? S_DONE : S_REACT;
      end
      S_DONE: w_state_n = r_start_e ? S_IDLE : S_DONE;
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_state <= S_IDLE;
      r_delay <= '0;
      r_score <= '0;
      r_fs <= 1'b0;
      r_lfsr <= LFSR_SEED;
      r_start_q <= 1'b0;
      r_react_q <= 1'b0;
      r_start_e <= 1'b0;
      r_react_e <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_delay <= w_delay_n;
      r_score <= w_score_n;
      r_fs <= w_fs_n;
      r_lfsr <= lfsr_next(r_lfsr);
      r_start_q <= start_btn;
      r_react_q <= react_btn;
      r_start_e <= start_btn & ~r_start_q;
      r_react_e <= react_btn & ~r_react_q;
    end
  end

  assign state = r_state;
  assign current_score = r_score;
  assign led_go = r_state == S_REACT;
  assign false_start = r_fs;
endmodule
